// File: rtl/keygen_sequencer_if.sv
// Input-RAM read port, key-generation core handshake and result-RAM write port
// driven by keygen_sequencer (master) toward the RAMs and core (slave).
interface keygen_sequencer_if #(
   parameter int DATA_WIDTH     = 1024,
   parameter int RAM_ADDR_WIDTH = 5
);
   logic [RAM_ADDR_WIDTH-1:0] in_rd_addr;
   logic [DATA_WIDTH/2-1:0]   p_dout;
   logic [DATA_WIDTH/2-1:0]   q_dout;
   logic                      core_start;
   logic [DATA_WIDTH/2-1:0]   core_p;
   logic [DATA_WIDTH/2-1:0]   core_q;
   logic                      core_done;
   logic [RAM_ADDR_WIDTH-1:0] out_wr_addr;
   logic                      out_wr_en;

   modport master (
      output in_rd_addr, core_start, core_p, core_q, out_wr_addr, out_wr_en,
      input  p_dout, q_dout, core_done
   );

   modport slave (
      input  in_rd_addr, core_start, core_p, core_q, out_wr_addr, out_wr_en,
      output p_dout, q_dout, core_done
   );
endinterface

// File: rtl/keygen_sequencer.sv
// Batch sequencer for the Paillier key-generation core: reads each (p, q) pair,
// launches the core, waits with a timeout and strobes the result-RAM write.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start after reset
// S_READ    | in_rd_addr presents idx to the p/q RAMs
// S_CAPTURE | RAM data valid, latched into core_p/core_q
// S_KICK    | one-cycle core_start pulse, timeout timer loaded
// S_WAIT    | waiting for core_done, timer counting down
// S_WRITE   | out_wr_en strobe at idx, advance or finish
// S_DONE    | batch finished (or aborted), start relaunches
module keygen_sequencer #(
   parameter int DATA_WIDTH     = 1024,
   parameter int RAM_ADDR_WIDTH = 5,
   parameter int FILE_SIZE      = 10,
   parameter int TIMEOUT        = 4096
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic [RAM_ADDR_WIDTH:0] entry_count,
   keygen_sequencer_if.master      bus
);
   localparam int HW = DATA_WIDTH / 2;
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [RAM_ADDR_WIDTH-1:0] LAST_IDX = RAM_ADDR_WIDTH'(FILE_SIZE - 1);
   localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_CAPTURE, S_KICK, S_WAIT, S_WRITE, S_DONE
   } state_t;

   state_t                    state, state_nxt;
   logic [RAM_ADDR_WIDTH-1:0] idx;
   logic [TW-1:0]             tmr;
   logic [HW-1:0]             core_p_r, core_q_r;
   logic                      error_r;
   logic [RAM_ADDR_WIDTH:0]   ent_cnt;
   logic                      accept;
   logic                      tmr_tc;

   assign accept = (state == S_IDLE || state == S_DONE) && start;
   assign tmr_tc = (tmr == '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE,
         S_DONE:    if (start) state_nxt = S_READ;
         S_READ:    state_nxt = S_CAPTURE;
         S_CAPTURE: state_nxt = S_KICK;
         S_KICK:    state_nxt = S_WAIT;
         // core_done takes priority over the timer reaching terminal count
         S_WAIT: begin
            if (bus.core_done) state_nxt = S_WRITE;
            else if (tmr_tc)   state_nxt = S_DONE;
         end
         S_WRITE:   state_nxt = (idx == LAST_IDX) ? S_DONE : S_READ;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         idx      <= '0;
         tmr      <= '0;
         core_p_r <= '0;
         core_q_r <= '0;
         error_r  <= 1'b0;
         ent_cnt  <= '0;
      end else begin
         if (accept) begin
            idx     <= '0;
            error_r <= 1'b0;
            ent_cnt <= '0;
         end
         if (state == S_CAPTURE) begin
            core_p_r <= bus.p_dout;
            core_q_r <= bus.q_dout;
         end
         // timer counts down from TIMEOUT-1 so terminal count is the TIMEOUT-th wait cycle
         if (state == S_KICK) tmr <= TMR_LOAD;
         if (state == S_WAIT && !bus.core_done) begin
            if (tmr_tc) error_r <= 1'b1;
            else        tmr     <= tmr - TW'(1);
         end
         if (state == S_WRITE) begin
            ent_cnt <= ent_cnt + (RAM_ADDR_WIDTH+1)'(1);
            if (idx != LAST_IDX) idx <= idx + RAM_ADDR_WIDTH'(1);
         end
      end
   end

   always_comb begin
      busy            = (state != S_IDLE) && (state != S_DONE);
      done            = (state == S_DONE);
      error           = error_r;
      entry_count     = ent_cnt;
      bus.in_rd_addr  = idx;
      bus.core_start  = (state == S_KICK);
      bus.core_p      = core_p_r;
      bus.core_q      = core_q_r;
      bus.out_wr_addr = idx;
      bus.out_wr_en   = (state == S_WRITE);
   end
endmodule

// File: tb/tb_keygen_sequencer.sv
// Directed bench for keygen_sequencer: a 10-entry instance and a 1-entry instance,
// both with an 8-cycle timeout, driven by simple RAM and core models.
module tb_keygen_sequencer;
   localparam int DW = 64;
   localparam int AW = 5;
   localparam int HW = DW / 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic start_a = 1'b0, start_b = 1'b0;
   logic busy_a, done_a, error_a, busy_b, done_b, error_b;
   logic [AW:0] ec_a, ec_b;

   keygen_sequencer_if #(.DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW)) bus_a ();
   keygen_sequencer_if #(.DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW)) bus_b ();

   keygen_sequencer #(.DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW), .FILE_SIZE(10), .TIMEOUT(8)) dut_a (
      .clock(clock), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
      .error(error_a), .entry_count(ec_a), .bus(bus_a)
   );

   keygen_sequencer #(.DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW), .FILE_SIZE(1), .TIMEOUT(8)) dut_b (
      .clock(clock), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
      .error(error_b), .entry_count(ec_b), .bus(bus_b)
   );

   logic [HW-1:0] p_mem [32];
   logic [HW-1:0] q_mem [32];
   int  core_k  = 3;
   bit  core_en = 1'b1;
   logic spur_a = 1'b0;
   logic cd_a = 1'b0, cd_b = 1'b0;
   int  cnt_a = 0, cnt_b = 0;
   bit  arm_a = 1'b0, arm_b = 1'b0;
   logic [AW-1:0] ra_a = '0, ra_b = '0;

   assign bus_a.core_done = cd_a | spur_a;
   assign bus_b.core_done = cd_b;

   // RAM data appears one cycle after the address; core_done k cycles after core_start
   always @(negedge clock) begin
      bus_a.p_dout = p_mem[ra_a];
      bus_a.q_dout = q_mem[ra_a];
      ra_a = bus_a.in_rd_addr;
      cd_a = 1'b0;
      if (!reset) arm_a = 1'b0;
      else if (bus_a.core_start) begin arm_a = 1'b1; cnt_a = core_k; end
      else if (arm_a) begin
         cnt_a--;
         if (cnt_a == 0) begin arm_a = 1'b0; cd_a = core_en; end
      end
   end

   always @(negedge clock) begin
      bus_b.p_dout = p_mem[ra_b];
      bus_b.q_dout = q_mem[ra_b];
      ra_b = bus_b.in_rd_addr;
      cd_b = 1'b0;
      if (!reset) arm_b = 1'b0;
      else if (bus_b.core_start) begin arm_b = 1'b1; cnt_b = core_k; end
      else if (arm_b) begin
         cnt_b--;
         if (cnt_b == 0) begin arm_b = 1'b0; cd_b = core_en; end
      end
   end

   int st_a = 0, pq_bad = 0, ent_a = 0, wr_b = 0;
   logic [AW-1:0] wr_q [$];
   logic [AW-1:0] wr_addr_b = '1;

   always @(negedge clock) begin
      if (!busy_a) ent_a = 0;
      if (bus_a.core_start) begin
         if (bus_a.core_p !== HW'(ent_a + 1) || bus_a.core_q !== HW'(ent_a + 17)) pq_bad++;
         ent_a++;
         st_a++;
      end
      if (bus_a.out_wr_en) wr_q.push_back(bus_a.out_wr_addr);
      if (bus_b.out_wr_en) begin wr_b++; wr_addr_b = bus_b.out_wr_addr; end
   end

   int n_chk = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic go(input bit sel_b);
      @(negedge clock);
      if (sel_b) start_b = 1'b1;
      else       start_a = 1'b1;
      @(posedge clock);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic wait_done(input bit sel_b, input int limit, output int n);
      n = 0;
      while (n < limit) begin
         @(posedge clock);
         n++;
         #1;
         if (sel_b ? done_b : done_a) break;
      end
   endtask

   task automatic chk_rst_outputs(input string tag);
      chk({tag, "_ctl"}, {busy_a, done_a, error_a, bus_a.core_start, bus_a.out_wr_en}, 0);
      chk({tag, "_cnt"}, ec_a, 0);
      chk({tag, "_pq"}, {bus_a.core_p, bus_a.core_q}, 0);
      chk({tag, "_addr"}, {bus_a.in_rd_addr, bus_a.out_wr_addr}, 0);
   endtask

   task automatic chk_addrs(input string tag, input int base);
      for (int i = 0; i < 10; i++)
         chk(tag, (base + i < wr_q.size()) ? wr_q[base + i] : '1, i);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, bs, bw, seen;
      for (int i = 0; i < 32; i++) begin
         p_mem[i] = HW'(i + 1);
         q_mem[i] = HW'(i + 17);
      end
      #1 reset = 1'b0;
      #2 chk_rst_outputs("rst0");
      repeat (3) @(posedge clock);
      @(negedge clock) reset = 1'b1;

      // 10 entries, core latency 3
      core_k = 3;
      bs = st_a; bw = wr_q.size();
      go(0);
      wait_done(0, 300, n);
      chk("b1_edges", n, 70);
      chk("b1_starts", st_a - bs, 10);
      chk("b1_writes", wr_q.size() - bw, 10);
      chk_addrs("b1_addr", bw);
      chk("b1_cnt", ec_a, 10);
      chk("b1_err_busy", {error_a, busy_a}, 0);

      // relaunch from DONE with a stray start in WAIT and a stray core_done in READ
      bs = st_a; bw = wr_q.size();
      go(0);
      chk("relaunch", {busy_a, done_a}, 2'b10);
      fork
         wait_done(0, 300, n);
         begin
            seen = 0;
            for (int i = 0; i < 300 && seen < 2; i++) begin
               @(negedge clock);
               if (bus_a.core_start) seen++;
            end
            @(negedge clock) start_a = 1'b1;
            @(negedge clock) start_a = 1'b0;
            for (int i = 0; i < 300; i++) begin
               @(negedge clock);
               if (bus_a.out_wr_en) break;
            end
            @(negedge clock) spur_a = 1'b1;
            @(negedge clock) spur_a = 1'b0;
         end
      join
      chk("ign_edges", n, 70);
      chk("ign_starts", st_a - bs, 10);
      chk("ign_writes", wr_q.size() - bw, 10);
      chk_addrs("ign_addr", bw);
      chk("ign_err", error_a, 0);

      // timeout abort: core never answers
      core_en = 1'b0;
      bs = st_a; bw = wr_q.size();
      go(0);
      wait_done(0, 100, n);
      chk("to_edges", n, 11);
      chk("to_err_done", {error_a, done_a}, 2'b11);
      chk("to_cnt", ec_a, 0);
      chk("to_writes", wr_q.size() - bw, 0);
      chk("to_starts", st_a - bs, 1);

      // new start clears error; reset during WAIT of entry 4
      core_en = 1'b1;
      bw = wr_q.size();
      go(0);
      chk("err_clr", error_a, 0);
      seen = 0;
      for (int i = 0; i < 300 && seen < 5; i++) begin
         @(negedge clock);
         if (bus_a.core_start) seen++;
      end
      @(posedge clock);
      #2;
      chk("mid_cnt", ec_a, 4);
      chk("mid_writes", wr_q.size() - bw, 4);
      reset = 1'b0;
      #1 chk_rst_outputs("rst_mid");
      repeat (2) @(posedge clock);
      @(negedge clock) reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 chk("idle_hold", {busy_a, done_a, bus_a.out_wr_en}, 0);
      bw = wr_q.size();
      go(0);
      wait_done(0, 300, n);
      chk("post_edges", n, 70);
      chk("post_writes", wr_q.size() - bw, 10);
      chk_addrs("post_addr", bw);
      chk("post_cnt", ec_a, 10);

      // core_done on the cycle the timer reaches terminal count
      core_k = 8;
      bw = wr_q.size();
      go(0);
      wait_done(0, 300, n);
      chk("race_edges", n, 120);
      chk("race_err", error_a, 0);
      chk("race_writes", wr_q.size() - bw, 10);
      chk("race_cnt", ec_a, 10);

      // single-entry batch, latency 1
      core_k = 1;
      go(1);
      wait_done(1, 50, n);
      chk("b_edges", n, 5);
      chk("b_cnt", ec_b, 1);
      chk("b_writes", wr_b, 1);
      chk("b_addr", wr_addr_b, 0);
      chk("b_err", error_b, 0);

      chk("core_pq", pq_bad, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
